sram_like_arbiter: RTL and testbench
====================================

// Module: sram_like_arbiter
// PURPOSE
//  Shares one SRAM-like memory port between the instruction-fetch requester (IF stage) and the
//  data requester (EXE issues load/store, MEM consumes data_rdata). One transaction in flight at a time.
//  Requests use req/addr_ok; responses use data_ok/rdata. Sits between the CPU core and the SRAM-like
//  bridge, replacing the separate inst/data SRAM ports.
// PARAMETERS
//  DATA_FIRST  1   1: data port has fixed priority when both request; 0: round-robin on last owner
// PORTS
//  clk           in   1   clock
//  reset         in   1   synchronous, active-high reset
//  inst_req      in   1   fetch request, held until inst_addr_ok
//  inst_addr     in   32  fetch address, stable while inst_req
//  inst_addr_ok  out  1   fetch request accepted by memory
//  inst_data_ok  out  1   fetch data valid this cycle
//  inst_rdata    out  32  fetch data
//  data_req      in   1   load/store request, held until data_addr_ok
//  data_wr       in   1   1=store, 0=load
//  data_size     in   2   0=byte, 1=half, 2=word
//  data_addr     in   32  load/store address
//  data_wdata    in   32  store data
//  data_addr_ok  out  1   load/store request accepted
//  data_data_ok  out  1   load data valid / store completed
//  data_rdata    out  32  load data (to MEM stage)
//  mem_req       out  1   request to memory
//  mem_wr        out  1   write flag to memory
//  mem_size      out  2   access size to memory
//  mem_addr      out  32  address to memory
//  mem_wdata     out  32  write data to memory
//  mem_addr_ok   in   1   memory accepted request
//  mem_data_ok   in   1   memory response valid
//  mem_rdata     in   32  memory read data
// BEHAVIOUR
//  - States: IDLE, ADDR, WAIT. Registers: state, owner (0=inst, 1=data), last_owner.
//  - IDLE: no request driven. Any req -> latch owner -> ADDR next cycle (one-cycle arbitration bubble).
//      Both req: DATA_FIRST=1 -> data; DATA_FIRST=0 -> port opposite last_owner.
//  - ADDR: mem_req=1; mem_* driven combinationally from owner's inputs.
//      Inst owner: mem_wr=0, mem_size=2, mem_wdata=0.
//      mem_addr_ok=1 -> owner's addr_ok=1 same cycle; go to WAIT; last_owner<=owner.
//  - WAIT: mem_req=0. mem_data_ok=1 -> owner's data_ok=1 same cycle -> IDLE.
//      Next grant is earliest the following cycle; no back-to-back overlap.
//  - inst_rdata=data_rdata=mem_rdata (pass-through). Only owner's data_ok asserts; the other stays 0.
//  - Non-owner addr_ok/data_ok always 0. Requester waiting during another's transaction keeps req high; no loss.
//  - Zero-latency memory (addr_ok and data_ok in consecutive cycles) is legal: ADDR->WAIT->IDLE, 3 cycles/txn.
//  - mem_data_ok outside WAIT is ignored (no data_ok forwarded, no state change).
//  - mem_addr_ok while not in ADDR is ignored.
//  - Requester dropping req in ADDR before addr_ok is a protocol violation.
//      Arbiter keeps driving mem_req until addr_ok; the transaction completes normally.
//  - Reset (any state, incl. mid-transaction): state=IDLE, owner=0, last_owner=1.
//      All outputs 0 the cycle after reset asserts. In-flight responses after reset are dropped.
//  - Reset values: mem_req/mem_wr/mem_size/mem_addr/mem_wdata=0; all addr_ok/data_ok=0; rdata outputs follow mem_rdata.
//  - In IDLE all mem_* outputs are 0 (no stale address toggling).
// TESTING
//  1. inst_req, addr=0xBFC00000; mem_addr_ok 1 cyc later, data_ok 2 cyc later, rdata=0x3C1D0000 ->
//     mem_addr=0xBFC00000, mem_wr=0, mem_size=2; inst_data_ok=1 with inst_rdata=0x3C1D0000; data_* ok stay 0.
//  2. inst_req and data_req same cycle (DATA_FIRST=1), data store size=0 addr=0x80000003 wdata=0xAB ->
//     data transaction first with mem_wr=1; inst granted in the cycle after data_data_ok.
//  3. DATA_FIRST=0, both req held continuously for 4 transactions -> grants alternate inst,data,inst,data.
//  4. Memory stalls: mem_addr_ok low 5 cycles, then data_ok after 7 more ->
//     mem_req held 5+1 cycles with stable addr; exactly one data_ok pulse to owner.
//  5. Reset in WAIT, then mem_data_ok=1 next cycle -> no data_ok to either port; state IDLE; mem_req=0.
//  6. Spurious mem_data_ok in IDLE -> ignored; inst/data data_ok remain 0.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Shares one SRAM-like memory port between the instruction-fetch requester and the data
//   (load/store) requester. Only one transaction is in flight at a time: a request is
//   arbitrated in IDLE, presented to memory in ADDR until mem_addr_ok, then the arbiter waits
//   in WAIT for mem_data_ok before returning to IDLE.
//
// Parameters
//   DATA_FIRST   1: data port wins when both request; 0: port opposite the last owner wins
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   inst_req/inst_addr            fetch request, held until inst_addr_ok
//   inst_addr_ok/inst_data_ok     fetch accepted / fetch data valid
//   inst_rdata                    fetch data (pass-through of mem_rdata)
//   data_req/wr/size/addr/wdata   load/store request, held until data_addr_ok
//   data_addr_ok/data_data_ok     load/store accepted / load data valid or store done
//   data_rdata                    load data (pass-through of mem_rdata)
//   mem_req/wr/size/addr/wdata    request to the memory bridge, all zero outside ADDR
//   mem_addr_ok/data_ok/rdata     memory handshake and read data

module sram_like_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StWait
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;            // 0 = inst, 1 = data
    logic   last_owner_q, last_owner_d;  // owner of the most recently accepted address
    logic   grant_data;

    // Arbitration winner, only consumed in IDLE.
    always_comb begin
        if (inst_req && data_req) begin
            grant_data = DATA_FIRST ? 1'b1 : ~last_owner_q;
        end else begin
            grant_data = data_req;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;

        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_size     = 2'd0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (inst_req || data_req) begin
                    owner_d = grant_data;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                // Held until accepted even if the requester drops req early.
                mem_req = 1'b1;
                if (owner_q) begin
                    mem_wr    = data_wr;
                    mem_size  = data_size;
                    mem_addr  = data_addr;
                    mem_wdata = data_wdata;
                end else begin
                    mem_size  = 2'd2;
                    mem_addr  = inst_addr;
                end
                if (mem_addr_ok) begin
                    data_addr_ok = owner_q;
                    inst_addr_ok = ~owner_q;
                    last_owner_d = owner_q;
                    state_d      = StWait;
                end
            end
            StWait: begin
                if (mem_data_ok) begin
                    data_data_ok = owner_q;
                    inst_data_ok = ~owner_q;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (reset) begin
            state_d      = StIdle;
            owner_d      = 1'b0;
            last_owner_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        owner_q      <= owner_d;
        last_owner_q <= last_owner_d;
    end

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter. Instance 0 uses DATA_FIRST=1, instance 1 uses DATA_FIRST=0.
// A transaction-level reference model predicts every output of both instances each cycle;
// directed steps add explicit checks, then a randomized phase runs both instances.

module tb_sram_like_arbiter;

    localparam bit DF0 = 1'b1;
    localparam bit DF1 = 1'b0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        inst_req     [2];
    logic [31:0] inst_addr    [2];
    logic        inst_addr_ok [2];
    logic        inst_data_ok [2];
    logic [31:0] inst_rdata   [2];
    logic        data_req     [2];
    logic        data_wr      [2];
    logic [1:0]  data_size    [2];
    logic [31:0] data_addr    [2];
    logic [31:0] data_wdata   [2];
    logic        data_addr_ok [2];
    logic        data_data_ok [2];
    logic [31:0] data_rdata   [2];
    logic        mem_req      [2];
    logic        mem_wr       [2];
    logic [1:0]  mem_size     [2];
    logic [31:0] mem_addr     [2];
    logic [31:0] mem_wdata    [2];
    logic        mem_addr_ok  [2];
    logic        mem_data_ok  [2];
    logic [31:0] mem_rdata    [2];

    sram_like_arbiter #(.DATA_FIRST(DF0)) u_dut_df (
        .clk(clk), .reset(reset),
        .inst_req(inst_req[0]), .inst_addr(inst_addr[0]), .inst_addr_ok(inst_addr_ok[0]),
        .inst_data_ok(inst_data_ok[0]), .inst_rdata(inst_rdata[0]),
        .data_req(data_req[0]), .data_wr(data_wr[0]), .data_size(data_size[0]),
        .data_addr(data_addr[0]), .data_wdata(data_wdata[0]), .data_addr_ok(data_addr_ok[0]),
        .data_data_ok(data_data_ok[0]), .data_rdata(data_rdata[0]),
        .mem_req(mem_req[0]), .mem_wr(mem_wr[0]), .mem_size(mem_size[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_addr_ok(mem_addr_ok[0]),
        .mem_data_ok(mem_data_ok[0]), .mem_rdata(mem_rdata[0])
    );

    sram_like_arbiter #(.DATA_FIRST(DF1)) u_dut_rr (
        .clk(clk), .reset(reset),
        .inst_req(inst_req[1]), .inst_addr(inst_addr[1]), .inst_addr_ok(inst_addr_ok[1]),
        .inst_data_ok(inst_data_ok[1]), .inst_rdata(inst_rdata[1]),
        .data_req(data_req[1]), .data_wr(data_wr[1]), .data_size(data_size[1]),
        .data_addr(data_addr[1]), .data_wdata(data_wdata[1]), .data_addr_ok(data_addr_ok[1]),
        .data_data_ok(data_data_ok[1]), .data_rdata(data_rdata[1]),
        .mem_req(mem_req[1]), .mem_wr(mem_wr[1]), .mem_size(mem_size[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_addr_ok(mem_addr_ok[1]),
        .mem_data_ok(mem_data_ok[1]), .mem_rdata(mem_rdata[1])
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: one open transaction record per instance.
    bit m_busy [2];   // a transaction owns the port (granted, not yet completed)
    bit m_who  [2];   // its requester, 1 = data
    bit m_sent [2];   // its address has been accepted
    bit m_last [2];   // requester of the last accepted address
    bit x_iaok [2];   // model's addr_ok predictions of the last evaluated cycle
    bit x_daok [2];

    int order[$];
    int nreq;
    int ndok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Evaluate the current cycle away from the clock edge, compare, advance the model.
    task automatic eval();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            logic        e_req, e_wr, e_iaok, e_daok, e_idok, e_ddok, df;
            logic [1:0]  e_size;
            logic [31:0] e_addr, e_wdata;
            string       p;
            e_req = 1'b0; e_wr = 1'b0; e_size = 2'd0; e_addr = 32'd0; e_wdata = 32'd0;
            e_iaok = 1'b0; e_daok = 1'b0; e_idok = 1'b0; e_ddok = 1'b0;
            df = (k == 0) ? DF0 : DF1;
            p = $sformatf("k%0d c%0d", k, cyc);
            if (reset) begin
                m_busy[k] = 1'b0; m_sent[k] = 1'b0; m_who[k] = 1'b0; m_last[k] = 1'b1;
                x_iaok[k] = 1'b0; x_daok[k] = 1'b0;
            end else begin
                if (m_busy[k] && !m_sent[k]) begin
                    e_req = 1'b1;
                    if (m_who[k]) begin
                        e_wr = data_wr[k]; e_size = data_size[k];
                        e_addr = data_addr[k]; e_wdata = data_wdata[k];
                    end else begin
                        e_size = 2'd2; e_addr = inst_addr[k];
                    end
                    if (mem_addr_ok[k]) begin
                        if (m_who[k]) e_daok = 1'b1; else e_iaok = 1'b1;
                        m_sent[k] = 1'b1;
                        m_last[k] = m_who[k];
                    end
                end else if (m_busy[k]) begin
                    if (mem_data_ok[k]) begin
                        if (m_who[k]) e_ddok = 1'b1; else e_idok = 1'b1;
                        m_busy[k] = 1'b0;
                    end
                end else if (inst_req[k] || data_req[k]) begin
                    m_busy[k] = 1'b1;
                    m_sent[k] = 1'b0;
                    if (inst_req[k] && data_req[k]) m_who[k] = df ? 1'b1 : !m_last[k];
                    else m_who[k] = data_req[k];
                end
                x_iaok[k] = e_iaok;
                x_daok[k] = e_daok;
                chk({p, " mem_req"},      32'(mem_req[k]),      32'(e_req));
                chk({p, " mem_wr"},       32'(mem_wr[k]),       32'(e_wr));
                chk({p, " mem_size"},     32'(mem_size[k]),     32'(e_size));
                chk({p, " mem_addr"},     mem_addr[k],          e_addr);
                chk({p, " mem_wdata"},    mem_wdata[k],         e_wdata);
                chk({p, " inst_addr_ok"}, 32'(inst_addr_ok[k]), 32'(e_iaok));
                chk({p, " data_addr_ok"}, 32'(data_addr_ok[k]), 32'(e_daok));
                chk({p, " inst_data_ok"}, 32'(inst_data_ok[k]), 32'(e_idok));
                chk({p, " data_data_ok"}, 32'(data_data_ok[k]), 32'(e_ddok));
                chk({p, " inst_rdata"},   inst_rdata[k],        mem_rdata[k]);
                chk({p, " data_rdata"},   data_rdata[k],        mem_rdata[k]);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            inst_req[k] = 1'b0; inst_addr[k] = 32'd0;
            data_req[k] = 1'b0; data_wr[k] = 1'b0; data_size[k] = 2'd0;
            data_addr[k] = 32'd0; data_wdata[k] = 32'd0;
            mem_addr_ok[k] = 1'b0; mem_data_ok[k] = 1'b0; mem_rdata[k] = 32'd0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        eval();
        adv();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        do_reset();

        // Reset state: idle, nothing driven.
        eval();
        chk("reset mem_req", 32'(mem_req[0]), 0);
        chk("reset mem_addr", mem_addr[0], 0);
        adv();

        // 1: single fetch.
        inst_req[0] = 1'b1; inst_addr[0] = 32'hBFC0_0000;
        eval(); chk("t1 arb bubble mem_req", 32'(mem_req[0]), 0); adv();
        mem_addr_ok[0] = 1'b1;
        eval();
        chk("t1 mem_addr", mem_addr[0], 32'hBFC0_0000);
        chk("t1 mem_wr", 32'(mem_wr[0]), 0);
        chk("t1 mem_size", 32'(mem_size[0]), 2);
        chk("t1 inst_addr_ok", 32'(inst_addr_ok[0]), 1);
        adv();
        inst_req[0] = 1'b0; mem_addr_ok[0] = 1'b0;
        mem_data_ok[0] = 1'b1; mem_rdata[0] = 32'h3C1D_0000;
        eval();
        chk("t1 inst_data_ok", 32'(inst_data_ok[0]), 1);
        chk("t1 inst_rdata", inst_rdata[0], 32'h3C1D_0000);
        chk("t1 data_data_ok", 32'(data_data_ok[0]), 0);
        chk("t1 data_addr_ok", 32'(data_addr_ok[0]), 0);
        adv();
        mem_data_ok[0] = 1'b0;
        eval(); chk("t1 back idle", 32'(mem_req[0]), 0); adv();

        // 2: simultaneous requests, data first.
        inst_req[0] = 1'b1; inst_addr[0] = 32'h0000_1000;
        data_req[0] = 1'b1; data_wr[0] = 1'b1; data_size[0] = 2'd0;
        data_addr[0] = 32'h8000_0003; data_wdata[0] = 32'h0000_00AB;
        eval(); adv();
        mem_addr_ok[0] = 1'b1;
        eval();
        chk("t2 mem_wr", 32'(mem_wr[0]), 1);
        chk("t2 mem_addr", mem_addr[0], 32'h8000_0003);
        chk("t2 mem_size", 32'(mem_size[0]), 0);
        chk("t2 mem_wdata", mem_wdata[0], 32'h0000_00AB);
        chk("t2 data_addr_ok", 32'(data_addr_ok[0]), 1);
        chk("t2 inst_addr_ok", 32'(inst_addr_ok[0]), 0);
        adv();
        data_req[0] = 1'b0; mem_addr_ok[0] = 1'b0; mem_data_ok[0] = 1'b1;
        eval();
        chk("t2 data_data_ok", 32'(data_data_ok[0]), 1);
        chk("t2 inst_data_ok", 32'(inst_data_ok[0]), 0);
        adv();
        mem_data_ok[0] = 1'b0;
        eval(); chk("t2 inst grant bubble", 32'(mem_req[0]), 0); adv();
        mem_addr_ok[0] = 1'b1;
        eval();
        chk("t2 inst mem_req", 32'(mem_req[0]), 1);
        chk("t2 inst mem_addr", mem_addr[0], 32'h0000_1000);
        chk("t2 inst mem_wr", 32'(mem_wr[0]), 0);
        chk("t2 inst_addr_ok", 32'(inst_addr_ok[0]), 1);
        adv();
        inst_req[0] = 1'b0; mem_addr_ok[0] = 1'b0; mem_data_ok[0] = 1'b1;
        eval(); chk("t2 inst_data_ok", 32'(inst_data_ok[0]), 1); adv();
        clear_inputs();

        // 3: round-robin on instance 1, both requests held, zero-latency memory.
        do_reset();
        inst_req[1] = 1'b1; inst_addr[1] = 32'h0000_2000;
        data_req[1] = 1'b1; data_addr[1] = 32'h0000_3000; data_size[1] = 2'd2;
        mem_addr_ok[1] = 1'b1; mem_data_ok[1] = 1'b1;
        order.delete();
        for (int i = 0; i < 40 && order.size() < 4; i++) begin
            eval();
            if (inst_addr_ok[1]) order.push_back(0);
            if (data_addr_ok[1]) order.push_back(1);
            adv();
        end
        chk("t3 grant count", order.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3 grant %0d owner", i), (i < order.size()) ? order[i] : -1, i % 2);
        end
        clear_inputs();
        do_reset();

        // 4: memory stalls.
        nreq = 0; ndok = 0;
        inst_req[0] = 1'b1; inst_addr[0] = 32'h0040_0000;
        eval(); adv();
        for (int i = 0; i < 5; i++) begin
            eval();
            if (mem_req[0]) nreq++;
            chk("t4 stall addr", mem_addr[0], 32'h0040_0000);
            adv();
        end
        mem_addr_ok[0] = 1'b1;
        eval(); if (mem_req[0]) nreq++; adv();
        inst_req[0] = 1'b0; mem_addr_ok[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_data_ok[0] = (i == 6);
            eval();
            if (mem_req[0]) nreq++;
            if (inst_data_ok[0]) ndok++;
            adv();
        end
        chk("t4 mem_req cycles", nreq, 6);
        chk("t4 data_ok pulses", ndok, 1);
        clear_inputs();

        // 5: reset while waiting for data, late response dropped.
        inst_req[0] = 1'b1; inst_addr[0] = 32'h0000_4000;
        eval(); adv();
        mem_addr_ok[0] = 1'b1;
        eval(); adv();
        inst_req[0] = 1'b0; mem_addr_ok[0] = 1'b0;
        reset = 1'b1;
        eval(); adv();
        reset = 1'b0; mem_data_ok[0] = 1'b1;
        eval();
        chk("t5 inst_data_ok", 32'(inst_data_ok[0]), 0);
        chk("t5 data_data_ok", 32'(data_data_ok[0]), 0);
        chk("t5 mem_req", 32'(mem_req[0]), 0);
        adv();
        mem_data_ok[0] = 1'b0;
        eval(); chk("t5 idle mem_req", 32'(mem_req[0]), 0); adv();

        // 6: spurious handshakes in IDLE.
        mem_data_ok[0] = 1'b1; mem_addr_ok[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("t6 inst_data_ok", 32'(inst_data_ok[0]), 0);
            chk("t6 data_data_ok", 32'(data_data_ok[0]), 0);
            chk("t6 mem_req", 32'(mem_req[0]), 0);
            adv();
        end
        clear_inputs();

        // Randomized traffic on both instances against the model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 2; k++) begin
                if (x_iaok[k]) inst_req[k] = 1'b0;
                if (x_daok[k]) data_req[k] = 1'b0;
                if (!inst_req[k] && $urandom_range(0, 2) == 0) begin
                    inst_req[k] = 1'b1;
                    inst_addr[k] = $urandom;
                end
                if (!data_req[k] && $urandom_range(0, 2) == 0) begin
                    data_req[k] = 1'b1;
                    data_wr[k] = 1'($urandom_range(0, 1));
                    data_size[k] = 2'($urandom_range(0, 2));
                    data_addr[k] = $urandom;
                    data_wdata[k] = $urandom;
                end
                mem_addr_ok[k] = ($urandom_range(0, 2) == 0);
                mem_data_ok[k] = ($urandom_range(0, 2) == 0);
                mem_rdata[k] = $urandom;
            end
            eval();
            adv();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
